// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver driven by an oversampling tick.
// Emits one data_valid pulse per good frame and flags framing errors.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e state_q, state_d;

  logic rx_meta_q;
  logic rx_sync_q;

  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic valid_q, valid_d;
  logic ferr_q, ferr_d;

  logic at_half;
  logic at_full;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign at_half = baud_tick && (tick_q == HALF_M1);
  assign at_full = baud_tick && (tick_q == FULL_M1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every decision is qualified by baud_tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (baud_tick && !rx_sync_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (at_half) begin
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_full && (bit_q == LAST_B)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_full) begin
          state_d = rx_sync_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (baud_tick && rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and shift register; they only move on baud_tick
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    if (baud_tick) begin
      unique case (state_q)
        S_IDLE: begin
          tick_d = '0;
          bit_d  = '0;
        end
        S_START: begin
          if (tick_q == HALF_M1) begin
            tick_d = '0;
            bit_d  = '0;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            bit_d   = bit_q + BW'(1);
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == FULL_M1) begin
            tick_d = '0;
            if (rx_sync_q) begin
              data_d = shift_q;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_BREAK: begin
          tick_d = '0;
        end
        default: begin
          tick_d = '0;
          bit_d  = '0;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  // Output decode: stop-bit sample decides valid versus framing error
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if ((state_q == S_STOP) && at_full) begin
      valid_d = rx_sync_q;
      ferr_d  = !rx_sync_q;
    end
  end

  // Pulse registers, aligned with the data update
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level model.
// Two instances: default (8 bits, x16, tick/4) and 7 bits, x8, tick always.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       tick_a, tick_b;
  logic       rx_a, rx_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       dv_a, fe_a, busy_a;
  logic       dv_b, fe_b, busy_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       err;
    logic [7:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic [7:0] good_a = 8'h00;
  logic [6:0] good_b = 7'h00;

  localparam int BIT_A = 64;
  localparam int BIT_B = 8;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) u_a (
    .clk        (clk),
    .reset      (rst_a),
    .baud_tick  (tick_a),
    .rx         (rx_a),
    .data       (data_a),
    .data_valid (dv_a),
    .frame_error(fe_a),
    .busy       (busy_a)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(8)) u_b (
    .clk        (clk),
    .reset      (rst_b),
    .baud_tick  (tick_b),
    .rx         (rx_b),
    .data       (data_b),
    .data_valid (dv_b),
    .frame_error(fe_b),
    .busy       (busy_b)
  );

  logic [1:0] tdiv = 2'd0;
  initial tick_a = 1'b0;
  always @(negedge clk) begin
    tdiv   <= tdiv + 2'd1;
    tick_a <= (tdiv == 2'd3);
  end
  assign tick_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_a && (dv_a || fe_a)) begin
      check("a_exclusive", 32'(dv_a && fe_a), 32'd0);
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: dv=%0b fe=%0b d=%0h expected none",
                 dv_a, fe_a, data_a);
      end else begin
        ea = qa.pop_front();
        check("a_kind", 32'(fe_a), 32'(ea.err));
        check("a_data", 32'(data_a), 32'(ea.d));
        check("a_busy", 32'(busy_a), 32'(ea.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && (dv_b || fe_b)) begin
      check("b_exclusive", 32'(dv_b && fe_b), 32'd0);
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: dv=%0b fe=%0b d=%0h expected none",
                 dv_b, fe_b, data_b);
      end else begin
        eb = qb.pop_front();
        check("b_kind", 32'(fe_b), 32'(eb.err));
        check("b_data", 32'(data_b), 32'(eb.d));
        check("b_busy", 32'(busy_b), 32'(eb.err));
      end
    end
  end

  task automatic hold_a(input logic b, input int clks);
    rx_a = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic hold_b(input logic b, input int clks);
    rx_b = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] v, input logic stop);
    exp_t e;
    e.err = ~stop;
    e.d   = stop ? v : good_a;
    if (stop) good_a = v;
    qa.push_back(e);
    hold_a(1'b0, BIT_A);
    for (int i = 0; i < 8; i++) hold_a(v[i], BIT_A);
    hold_a(stop, BIT_A);
  endtask

  task automatic send_b(input logic [6:0] v, input logic stop);
    exp_t e;
    e.err = ~stop;
    e.d   = {1'b0, stop ? v : good_b};
    if (stop) good_b = v;
    qb.push_back(e);
    hold_b(1'b0, BIT_B);
    for (int i = 0; i < 7; i++) hold_b(v[i], BIT_B);
    hold_b(stop, BIT_B);
  endtask

  task automatic run_a();
    logic [7:0] v;
    logic       s;
    logic [7:0] r55;
    rst_a = 1'b1;
    rx_a  = 1'b1;
    repeat (5) @(negedge clk);
    check("a_rst_data", 32'(data_a), 32'd0);
    check("a_rst_dv", 32'(dv_a), 32'd0);
    check("a_rst_fe", 32'(fe_a), 32'd0);
    check("a_rst_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    hold_a(1'b1, 2 * BIT_A);
    send_a(8'hA5, 1'b1);
    hold_a(1'b1, BIT_A);
    send_a(8'h00, 1'b1);
    send_a(8'hFF, 1'b1);
    hold_a(1'b1, 2 * BIT_A);
    hold_a(1'b0, 12);
    check("a_glitch_busy", 32'(busy_a), 32'd1);
    hold_a(1'b1, BIT_A);
    check("a_glitch_idle", 32'(busy_a), 32'd0);
    check("a_glitch_data", 32'(data_a), 32'(good_a));
    send_a(8'h3C, 1'b0);
    hold_a(1'b0, 40 * BIT_A);
    check("a_break_busy", 32'(busy_a), 32'd1);
    check("a_break_data", 32'(data_a), 32'(good_a));
    hold_a(1'b1, 2 * BIT_A);
    send_a(8'h81, 1'b1);
    hold_a(1'b1, BIT_A);
    r55 = 8'h55;
    hold_a(1'b0, BIT_A);
    for (int i = 0; i < 4; i++) hold_a(r55[i], BIT_A);
    hold_a(r55[4], BIT_A / 2);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("a_mid_data", 32'(data_a), 32'd0);
    check("a_mid_dv", 32'(dv_a), 32'd0);
    check("a_mid_fe", 32'(fe_a), 32'd0);
    check("a_mid_busy", 32'(busy_a), 32'd0);
    good_a = 8'h00;
    hold_a(1'b1, 2 * BIT_A);
    send_a(8'h55, 1'b1);
    hold_a(1'b1, BIT_A);
    for (int n = 0; n < 16; n++) begin
      v = 8'($urandom);
      s = ($urandom_range(3) != 0);
      send_a(v, s);
      if (!s || $urandom_range(1) == 1) hold_a(1'b1, BIT_A);
    end
    hold_a(1'b1, 3 * BIT_A);
  endtask

  task automatic run_b();
    logic [6:0] v;
    logic       s;
    rst_b = 1'b1;
    rx_b  = 1'b1;
    repeat (5) @(negedge clk);
    check("b_rst_data", 32'(data_b), 32'd0);
    check("b_rst_busy", 32'(busy_b), 32'd0);
    rst_b = 1'b0;
    hold_b(1'b1, 2 * BIT_B);
    send_b(7'h5A, 1'b1);
    hold_b(1'b1, BIT_B);
    for (int n = 0; n < 30; n++) begin
      v = 7'($urandom);
      s = ($urandom_range(3) != 0);
      send_b(v, s);
      if (!s || $urandom_range(1) == 1) hold_b(1'b1, BIT_B);
    end
    hold_b(1'b1, 3 * BIT_B);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    check("a_queue_empty", 32'(qa.size()), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: recovers 8N1-style frames from the asynchronous serial line `rx` using the 16x oversampling tick produced by the baud generator (`baud_tick`, one `clk` cycle wide, 16 per bit period).
- Sits between the pad and the byte-consumer logic.
- Outputs each good byte with a one-cycle `data_valid` strobe, and flags framing errors.

Parameters:
- DATA_BITS, 8, data bits per frame (LSB first); legal range 5..9.
- OVERSAMPLE, 16, `baud_tick` pulses per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- baud_tick  input  1  oversample enable, one clk cycle wide, OVERSAMPLE per bit
- rx  input  1  asynchronous serial line, idle high
- data  output  DATA_BITS  last correctly received byte; held until next good frame
- data_valid  output  1  one-cycle pulse: `data` just updated
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is synchronous and active-high.
- Input synchronizer:
  - `rx` passes through 2 flops (`rx_sync`); both reset to 1.
  - All decisions use `rx_sync` and are taken only in cycles where `baud_tick`=1.
  - Counters advance only on `baud_tick`.
- Reset values:
  - data=0, data_valid=0, frame_error=0, busy=0.
  - state=IDLE; tick_cnt=0, bit_cnt=0, shift register=0.
- Reset mid-frame: abandons the frame immediately; no valid or error pulse is produced.
- Counter widths: `tick_cnt` is clog2(OVERSAMPLE) bits; `bit_cnt` is clog2(DATA_BITS+1) bits.
- State machine:
  - IDLE: on tick with rx_sync=0 -> START, tick_cnt=0.
  - START: on each tick tick_cnt++.
    - At the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_sync.
    - Sample =1 -> glitch: back to IDLE, no outputs.
    - Sample =0 -> DATA, tick_cnt=0, bit_cnt=0.
  - DATA: on each tick tick_cnt++.
    - At tick_cnt==OVERSAMPLE-1 (mid data bit): shift rx_sync in at the MSB of the shift register (right shift), so the first bit ends at data[0]; tick_cnt=0; bit_cnt++.
    - When bit_cnt reaches DATA_BITS -> STOP.
  - STOP: at tick_cnt==OVERSAMPLE-1, sample rx_sync.
    - Sample =1: data<=shift register, data_valid=1 for exactly one clk, -> IDLE.
    - Sample =0: frame_error=1 for exactly one clk, data unchanged, -> BREAK.
  - BREAK: stays until a tick with rx_sync=1 -> IDLE. This means a held-low line (break) does not retrigger frames.
- Output timing:
  - data_valid and data change on the clk edge that processes the stop-bit sample tick.
  - data_valid and frame_error are never high together.
  - Both are low whenever baud_tick is low, apart from their single pulse cycle.
- Back-to-back frames: a start bit may begin on the tick immediately after the stop-bit sample. IDLE is re-entered in the same cycle data_valid pulses, so no gap is required.
- No FIFO and no overrun detection: the consumer must take `data` before the next data_valid. `data` is stable until then.
- baud_tick held high every cycle is legal: the block then oversamples at the clk rate.

Test Plan:
- Basic byte: baud_tick every 4 clks, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), each bit 64 clks -> exactly one data_valid pulse, data=0xA5, frame_error never high, busy falls in the valid cycle.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two data_valid pulses about 640 clks apart; data=0x00 then 0xFF.
- Glitch reject: drive rx low for 3 ticks (12 clks) then high -> busy pulses, returns to IDLE before the mid-start sample, no data_valid, no frame_error, data unchanged.
- Framing error: send 0x3C with stop bit 0, then hold rx low 40 bit-times, then release and send 0x81 -> one frame_error pulse; data keeps its previous value; no further pulses during the low hold; then data_valid with data=0x81.
- Reset mid-frame: assert reset for 1 clk during bit 4 of 0x55 -> all outputs 0 the next cycle, no pulse for that frame; following frame 0x55 is received correctly.
- Parameter sweep: DATA_BITS=7, OVERSAMPLE=8, baud_tick every clk, send 0x5A -> data=0x5A (7 bits), one data_valid pulse.
